// File: rtl/mux2to1_arbiter_pkg.sv
// Shared definitions for the round-robin mux2to1 arbiter: FSM state encoding
// and the default data width / hold-time constants.
package mux2to1_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/mux2to1_arbiter_mux.sv
// The existing two-input mux shared by both requesters; purely combinational.
module mux2to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] muxout
);

    assign muxout = sel ? i1 : i0;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Round-robin grant FSM with bounded hold time driving the shared mux select,
// plus a registered output stage tagged with valid and source.
module mux2to1_arbiter
    import mux2to1_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_src
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t        state, state_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic              last_served, last_nxt;
    logic [WIDTH-1:0]  muxout;
    logic              xfer;

    mux2to1 #(.WIDTH(WIDTH)) u_mux (
        .i0     (i0),
        .i1     (i1),
        .sel    (sel),
        .muxout (muxout)
    );

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);
    assign sel  = gnt1;
    assign xfer = (gnt0 & req0) | (gnt1 & req1);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last_served;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last_served ? G0 : G1;
                else if (req0)
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
            end
            G0: begin
                if (!req0)
                    state_nxt = req1 ? G1 : IDLE;
                else if (hold_cnt == HOLD_LAST) begin
                    // Rotate only if the partner is waiting; otherwise restart the window.
                    if (req1)
                        state_nxt = G1;
                    else
                        hold_nxt = '0;
                end else
                    hold_nxt = hold_cnt + 1'b1;
            end
            G1: begin
                if (!req1)
                    state_nxt = req0 ? G0 : IDLE;
                else if (hold_cnt == HOLD_LAST) begin
                    if (req0)
                        state_nxt = G0;
                    else
                        hold_nxt = '0;
                end else
                    hold_nxt = hold_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // Any fresh grant starts a new hold window and records its owner.
        if (state_nxt != state && state_nxt == G0) begin
            hold_nxt = '0;
            last_nxt = 1'b0;
        end else if (state_nxt != state && state_nxt == G1) begin
            hold_nxt = '0;
            last_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            last_served <= last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= muxout;
                out_src  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Randomized bench for mux2to1_arbiter against a run-length reference model,
// preceded by the directed reset / hold / switch scenarios.
module tb_mux2to1_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n, req0, req1;
    logic [WIDTH-1:0] i0, i1;
    logic             gnt0, gnt1, sel, out_valid, out_src;
    logic [WIDTH-1:0] out_data;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: owner 2 = nobody, run = consecutive cycles owned.
    int               m_owner = 2;
    int               m_run   = 0;
    int               m_last  = 1;
    logic             m_valid = 1'b0;
    logic             m_src   = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;

    mux2to1_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .i0        (i0),
        .i1        (i1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge(input logic rst, input logic r0, input logic r1,
                              input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        int nxt;
        logic rx, ry;
        if (!rst) begin
            m_owner = 2; m_run = 0; m_last = 1;
            m_valid = 1'b0; m_data = '0; m_src = 1'b0;
            return;
        end
        if ((m_owner == 0 && r0) || (m_owner == 1 && r1)) begin
            m_valid = 1'b1;
            m_data  = (m_owner == 1) ? d1 : d0;
            m_src   = (m_owner == 1);
        end else
            m_valid = 1'b0;
        if (m_owner == 2) begin
            if (r0 && r1)      nxt = 1 - m_last;
            else if (r0)       nxt = 0;
            else if (r1)       nxt = 1;
            else               nxt = 2;
        end else begin
            rx = (m_owner == 0) ? r0 : r1;
            ry = (m_owner == 0) ? r1 : r0;
            if (!rx)
                nxt = ry ? 1 - m_owner : 2;
            else if (ry && (m_run % MAX_HOLD) == MAX_HOLD - 1)
                nxt = 1 - m_owner;
            else
                nxt = m_owner;
        end
        if (nxt != m_owner && nxt != 2) begin
            m_run  = 0;
            m_last = nxt;
        end else if (nxt == m_owner && nxt != 2)
            m_run++;
        m_owner = nxt;
    endtask

    task automatic check_all();
        chk("gnt0",      {31'd0, gnt0},      {31'd0, m_owner == 0});
        chk("gnt1",      {31'd0, gnt1},      {31'd0, m_owner == 1});
        chk("sel",       {31'd0, sel},       {31'd0, m_owner == 1});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_src",   {31'd0, out_src},   {31'd0, m_src});
        chk("out_data",  out_data,           m_data);
    endtask

    // Called at a falling edge: drive, let the rising edge happen, check at the next fall.
    task automatic cycle(input logic rst, input logic r0, input logic r1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        rst_n = rst; req0 = r0; req1 = r1; i0 = d0; i1 = d1;
        @(posedge clk);
        model_edge(rst, r0, r1, d0, d1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; i0 = 32'd3; i1 = 32'd5;
        @(negedge clk);

        // Reset held with both requests up.
        cycle(1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
        cycle(1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_data", out_data, 32'd0);

        // Release: requester 0 wins the first tie, then 4/4 rotation.
        cycle(1'b1, 1'b1, 1'b1, 32'd3, 32'd5);
        chk("rel_gnt0", {31'd0, gnt0}, 32'd1);
        for (int k = 0; k < 11; k++)
            cycle(1'b1, 1'b1, 1'b1, 32'd3, 32'd5);

        // Requester 0 alone keeps the grant past MAX_HOLD.
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
        chk("solo_gnt0", {31'd0, gnt0}, 32'd1);
        chk("solo_data", out_data, 32'd3);

        // Drop req0 while requester 1 waits: direct switch, no bubble.
        cycle(1'b1, 1'b0, 1'b1, 32'd3, 32'd5);
        chk("sw_sel", {31'd0, sel}, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'd3, 32'd5);
        chk("sw_data", out_data, 32'd5);
        chk("sw_src", {31'd0, out_src}, 32'd1);

        // Drop req1 with nobody else: IDLE, data holds.
        cycle(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        cycle(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_data", out_data, 32'd5);

        // Reset in the middle of G1; tie afterwards goes to requester 0.
        cycle(1'b1, 1'b0, 1'b1, 32'd3, 32'd5);
        cycle(1'b1, 1'b1, 1'b1, 32'd3, 32'd5);
        cycle(1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
        chk("mid_rst_gnt1", {31'd0, gnt1}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'd3, 32'd5);
        chk("mid_rst_tie", {31'd0, gnt0}, 32'd1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
